// File: rtl/mux_round_robin_arbiter.sv
// Round-robin arbiter driving the select lines of a 4:1 one-bit mux, with a
// registered data/valid output and a hold limit that bounds bursts under contention.
module mux_round_robin_arbiter #(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic       addr0,
    output logic       addr1,
    output logic       out,
    output logic       valid,
    output logic       busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_cur;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold;
    logic [3:0]       r_gnt;
    logic             r_out;
    logic             r_valid;

    logic             w_cur_req;
    logic             w_others;
    logic             w_hold_max;
    logic             w_release;
    logic [1:0]       w_start;
    logic [1:0]       w_idx;
    logic [1:0]       w_win;
    logic             w_found;

    assign w_cur_req  = req[r_cur];
    assign w_others   = |(req & ~(4'b0001 << r_cur));
    assign w_hold_max = (r_hold == CNT_W'(HOLD_MAX));
    assign w_release  = (r_state == GRANT) && (!w_cur_req || (w_hold_max && w_others));
    // On release the search starts just past the grantee, so it is considered last.
    assign w_start    = (r_state == GRANT) ? r_cur + 2'd1 : r_ptr;

    always_comb begin
        w_found = 1'b0;
        w_win   = w_start;
        w_idx   = w_start;
        for (int unsigned k = 0; k < 4; k++) begin
            w_idx = w_start + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cur   <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_out   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_cur   <= w_win;
                        r_gnt   <= 4'b0001 << w_win;
                        r_hold  <= CNT_W'(1);
                    end
                end
                default: begin
                    if (w_release) begin
                        r_ptr <= r_cur + 2'd1;
                        if (w_found) begin
                            r_cur  <= w_win;
                            r_gnt  <= 4'b0001 << w_win;
                            r_hold <= CNT_W'(1);
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                        end
                    end else if (!w_hold_max) begin
                        r_hold <= r_hold + CNT_W'(1);
                    end
                end
            endcase

            if ((r_state == GRANT) && w_cur_req) begin
                r_out   <= din[r_cur];
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign gnt   = r_gnt;
    assign addr1 = r_cur[1];
    assign addr0 = r_cur[0];
    assign out   = r_out;
    assign valid = r_valid;
    assign busy  = |r_gnt;

endmodule

// File: tb/tb_mux_round_robin_arbiter.sv
// Bench for mux_round_robin_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural arbiter model.
module tb_mux_round_robin_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       addr0, addr1, out, valid, busy;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model: grantee index (-1 = nobody), rotation start, burst length.
    int m_g     = -1;
    int m_ptr   = 0;
    int m_cur   = 0;
    int m_burst = 0;
    bit m_out   = 1'b0;
    bit m_valid = 1'b0;

    mux_round_robin_arbiter #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .gnt(gnt),
        .addr0(addr0), .addr1(addr1), .out(out), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic m_update(input logic rs, input logic [3:0] r, input logic [3:0] d);
        int  w;
        bit  others;
        if (rs) begin
            m_g = -1; m_ptr = 0; m_cur = 0; m_burst = 0; m_out = 0; m_valid = 0;
        end else begin
            if (m_g >= 0 && r[m_g]) begin
                m_out = d[m_g];
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
            if (m_g < 0) begin
                w = search(r, m_ptr);
                if (w >= 0) begin
                    m_g = w; m_cur = w; m_burst = 1;
                end
            end else begin
                others = 0;
                for (int j = 0; j < 4; j++) if (j != m_g && r[j]) others = 1;
                if (!r[m_g] || (m_burst >= HOLD && others)) begin
                    m_ptr = (m_g + 1) % 4;
                    w = search(r, m_ptr);
                    if (w >= 0) begin
                        m_g = w; m_cur = w; m_burst = 1;
                    end else begin
                        m_g = -1;
                    end
                end else if (m_burst < HOLD) begin
                    m_burst++;
                end
            end
        end
    endtask

    task automatic step(input logic rs, input logic [3:0] rq, input logic [3:0] d);
        reset = rs; req = rq; din = d;
        @(posedge clk);
        m_update(rs, rq, d);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_gnt",   int'(gnt), (m_g < 0) ? 0 : (1 << m_g));
            check("model_addr",  int'({addr1, addr0}), m_cur);
            check("model_out",   int'(out), int'(m_out));
            check("model_valid", int'(valid), int'(m_valid));
            check("model_busy",  int'(busy), (m_g >= 0) ? 1 : 0);
        end
    end

    initial begin
        logic [3:0] rq;
        logic       rs;

        // Reset with everything requesting
        step(1'b1, 4'b1111, 4'b1111);
        cmp_en = 1'b1;
        step(1'b1, 4'b1111, 4'b1111);
        check("rst_gnt",   int'(gnt), 0);
        check("rst_addr",  int'({addr1, addr0}), 0);
        check("rst_out",   int'(out), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_busy",  int'(busy), 0);
        step(1'b0, 4'b1111, 4'b1111);
        check("post_rst_gnt", int'(gnt), 1);

        // Single requester
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0100, 4'b0100);
        check("single_gnt",   int'(gnt), 4);
        check("single_addr",  int'({addr1, addr0}), 2);
        check("single_valid0", int'(valid), 0);
        step(1'b0, 4'b0100, 4'b0100);
        check("single_out",   int'(out), 1);
        check("single_valid", int'(valid), 1);
        step(1'b0, 4'b0000, 4'b0100);
        check("single_drop_gnt",   int'(gnt), 0);
        check("single_drop_valid", int'(valid), 0);

        // Full load: HOLD cycles each, in order 0,1,2,3,0...
        step(1'b1, 4'b0000, 4'b0000);
        for (int s = 0; s < 20; s++) begin
            step(1'b0, 4'b1111, 4'($urandom));
            check("full_gnt",  int'(gnt), 1 << ((s / HOLD) % 4));
            check("full_addr", int'({addr1, addr0}), (s / HOLD) % 4);
        end

        // No contention: unbounded burst
        step(1'b1, 4'b0000, 4'b0000);
        for (int s = 0; s < 12; s++) begin
            step(1'b0, 4'b0010, 4'b0010);
            check("nocont_gnt", int'(gnt), 2);
            if (s >= 1) check("nocont_valid", int'(valid), 1);
        end

        // Handoff from 3 wrapping to 0 with no idle cycle
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b1000, 4'b0000);
        check("wrap_gnt3", int'(gnt), 8);
        step(1'b0, 4'b1001, 4'b0000);
        check("wrap_hold3", int'(gnt), 8);
        step(1'b0, 4'b0001, 4'b0001);
        check("wrap_gnt0", int'(gnt), 1);
        step(1'b0, 4'b0001, 4'b0001);
        check("wrap_out1", int'(out), 1);
        step(1'b0, 4'b0001, 4'b0000);
        check("wrap_out0", int'(out), 0);
        check("wrap_valid", int'(valid), 1);

        // Reset mid-burst clears the rotation pointer
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        check("mid_gnt", int'(gnt), 4);
        step(1'b1, 4'b0100, 4'b1111);
        check("mid_rst_gnt",   int'(gnt), 0);
        check("mid_rst_valid", int'(valid), 0);
        step(1'b0, 4'b0110, 4'b0000);
        check("mid_first_gnt", int'(gnt), 2);

        // Random traffic; a requester only drops once its grant is visible
        rq = 4'b0110;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!rq[i]) begin
                    if ($urandom_range(3) == 0) rq[i] = 1'b1;
                end else if (m_g == i && $urandom_range(2) == 0) begin
                    rq[i] = 1'b0;
                end
            end
            rs = ($urandom_range(199) == 0);
            step(rs, rq, 4'($urandom));
        end

        cmp_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
